// File: rtl/datapath_ctrl_if.sv
// Instruction handshake and datapath control bundle for datapath_ctrl.
// slave is the controller side, master is the fetch/datapath side.
interface datapath_ctrl_if #(
  parameter int PC_W = 8
);
  logic [15:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic            C;
  logic            N;
  logic            Z;
  logic [2:0]      R_Adr;
  logic [2:0]      S_Adr;
  logic [2:0]      W_Adr;
  logic [3:0]      ALU_OP;
  logic            S_Sel;
  logic [15:0]     DS;
  logic            W_En;
  logic [PC_W-1:0] pc;
  logic [2:0]      flags;
  logic            busy;

  modport slave (
    input  instr, instr_valid, C, N, Z,
    output instr_ready, R_Adr, S_Adr, W_Adr,
    output ALU_OP, S_Sel, DS, W_En,
    output pc, flags, busy
  );

  modport master (
    output instr, instr_valid, C, N, Z,
    input  instr_ready, R_Adr, S_Adr, W_Adr,
    input  ALU_OP, S_Sel, DS, W_En,
    input  pc, flags, busy
  );
endinterface

// File: rtl/datapath_ctrl.sv
// Multi-cycle controller: IDLE -> EXEC -> WB for ALU/LDI, IDLE -> BR for
// branches. All outputs come straight from flops.
module datapath_ctrl #(
  parameter int         PC_W    = 8,
  parameter logic [3:0] PASS_OP = 4'hF
) (
  input  logic          clk,
  input  logic          reset,
  datapath_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB,
    BR
  } state_t;

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [11:0]     br_q, br_d;
  logic [2:0]      r_adr_q, r_adr_d;
  logic [2:0]      s_adr_q, s_adr_d;
  logic [2:0]      w_adr_q, w_adr_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            s_sel_q, s_sel_d;
  logic [15:0]     ds_q, ds_d;
  logic            w_en_q, w_en_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      flags_q, flags_d;
  logic [3:0]      op;
  logic            taken;

  assign op = bus.instr[15:12];

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    br_d     = br_q;
    r_adr_d  = r_adr_q;
    s_adr_d  = s_adr_q;
    w_adr_d  = w_adr_q;
    alu_op_d = alu_op_q;
    s_sel_d  = s_sel_q;
    ds_d     = ds_q;
    w_en_d   = 1'b0;
    pc_d     = pc_q;
    flags_d  = flags_q;
    taken    = 1'b0;

    // flags are {C,N,Z}; only the WB-latched copy is ever tested
    unique case (br_q[11:10])
      2'b00:   taken = 1'b1;
      2'b01:   taken = flags_q[0];
      2'b10:   taken = flags_q[1];
      default: taken = flags_q[2];
    endcase

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (ready_q && bus.instr_valid) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (op == 4'hF) begin
            state_d = BR;
            br_d    = bus.instr[11:0];
          end else begin
            state_d = EXEC;
            w_adr_d = bus.instr[11:9];
            if (op == 4'hE) begin
              r_adr_d  = 3'd0;
              s_adr_d  = 3'd0;
              alu_op_d = PASS_OP;
              s_sel_d  = 1'b1;
              ds_d     = 16'($signed(bus.instr[8:0]));
            end else begin
              r_adr_d  = bus.instr[8:6];
              s_adr_d  = bus.instr[5:3];
              alu_op_d = op;
              s_sel_d  = 1'b0;
              ds_d     = 16'd0;
            end
          end
        end
      end
      EXEC: begin
        state_d = WB;
        w_en_d  = 1'b1;
      end
      WB: begin
        state_d = IDLE;
        flags_d = {bus.C, bus.N, bus.Z};
        pc_d    = pc_q + PC_W'(1);
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      BR: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (taken) begin
          pc_d = pc_q + PC_W'($signed(br_q[9:0]));
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      br_q     <= '0;
      r_adr_q  <= '0;
      s_adr_q  <= '0;
      w_adr_q  <= '0;
      alu_op_q <= '0;
      s_sel_q  <= 1'b0;
      ds_q     <= '0;
      w_en_q   <= 1'b0;
      pc_q     <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      br_q     <= br_d;
      r_adr_q  <= r_adr_d;
      s_adr_q  <= s_adr_d;
      w_adr_q  <= w_adr_d;
      alu_op_q <= alu_op_d;
      s_sel_q  <= s_sel_d;
      ds_q     <= ds_d;
      w_en_q   <= w_en_d;
      pc_q     <= pc_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.R_Adr       = r_adr_q;
  assign bus.S_Adr       = s_adr_q;
  assign bus.W_Adr       = w_adr_q;
  assign bus.ALU_OP      = alu_op_q;
  assign bus.S_Sel       = s_sel_q;
  assign bus.DS          = ds_q;
  assign bus.W_En        = w_en_q;
  assign bus.pc          = pc_q;
  assign bus.flags       = flags_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: directed scenarios plus a random instruction
// stream checked against an instruction-level model of pc and flags.
module tb_datapath_ctrl;

  localparam int PCW = 8;
  localparam int PCM = 1 << PCW;

  logic clk = 1'b0;
  logic reset = 1'b0;

  datapath_ctrl_if #(.PC_W(PCW)) bus ();

  datapath_ctrl #(.PC_W(PCW), .PASS_OP(4'hF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wen_cnt = 0;

  always @(negedge clk) begin
    if (bus.W_En === 1'b1) wen_cnt <= wen_cnt + 1;
  end

  // model state
  int       m_pc = 0;
  logic [2:0] m_flags = 3'b000;

  // observations captured by the driver
  bit          o_to;
  logic [2:0]  o_r, o_s, o_w, o_flags;
  logic [3:0]  o_op;
  logic        o_ssel, o_wen_ex, o_rdy_ex, o_busy;
  logic        o_wen_wb, o_wen_end, o_rdy;
  logic [15:0] o_ds;
  logic [PCW-1:0] o_pc;

  function automatic int wrap(input int v);
    return ((v % PCM) + PCM) % PCM;
  endfunction

  function automatic int sx(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  function automatic bit br_taken(input logic [1:0] c,
                                  input logic [2:0] f);
    case (c)
      2'd0: return 1'b1;
      2'd1: return f[0];
      2'd2: return f[1];
      default: return f[2];
    endcase
  endfunction

  // Issues one instruction at a negedge and records what the DUT shows.
  task automatic run(input logic [15:0] w, input logic [2:0] cnz,
                     input bit tog);
    int k;
    o_to = 1'b0;
    k = 0;
    while (bus.instr_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.instr_ready !== 1'b1) begin
      o_to = 1'b1;
      return;
    end
    bus.instr = w;
    bus.instr_valid = 1'b1;
    {bus.C, bus.N, bus.Z} = cnz;
    @(posedge clk);
    #1;
    bus.instr_valid = tog;
    bus.instr = 16'($urandom);
    @(negedge clk);
    o_r = bus.R_Adr;
    o_s = bus.S_Adr;
    o_w = bus.W_Adr;
    o_op = bus.ALU_OP;
    o_ssel = bus.S_Sel;
    o_ds = bus.DS;
    o_wen_ex = bus.W_En;
    o_rdy_ex = bus.instr_ready;
    o_busy = bus.busy;
    o_wen_wb = 1'b0;
    if (w[15:12] != 4'hF) begin
      bus.instr_valid = tog & 1'($urandom);
      bus.instr = 16'($urandom);
      @(negedge clk);
      o_wen_wb = bus.W_En;
    end
    bus.instr_valid = tog & 1'($urandom);
    bus.instr = 16'($urandom);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    o_wen_end = bus.W_En;
    o_rdy = bus.instr_ready;
    o_pc = bus.pc;
    o_flags = bus.flags;
  endtask

  task automatic goto_pc(input int t);
    int d;
    d = wrap(t - m_pc);
    if (d >= PCM / 2) d -= PCM;
    run({4'hF, 2'b00, 10'(d)}, 3'b000, 1'b0);
    m_pc = t;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0;
    {bus.C, bus.N, bus.Z} = 3'b000;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.instr_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_ready got %b exp 0", bus.instr_ready);
    end
    tests++;
    if ({bus.W_En, bus.S_Sel, bus.busy} !== 3'b000) begin
      fails++;
      $display("FAIL rst_ctl got %b exp 000",
               {bus.W_En, bus.S_Sel, bus.busy});
    end
    tests++;
    if ({bus.pc, bus.flags, bus.ALU_OP, bus.DS} !== '0) begin
      fails++;
      $display("FAIL rst_regs pc %0h fl %0h op %0h ds %0h exp 0",
               bus.pc, bus.flags, bus.ALU_OP, bus.DS);
    end
    tests++;
    if ({bus.R_Adr, bus.S_Adr, bus.W_Adr} !== 9'd0) begin
      fails++;
      $display("FAIL rst_adr got %0h exp 0",
               {bus.R_Adr, bus.S_Adr, bus.W_Adr});
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_release_ready got %b exp 1", bus.instr_ready);
    end
    m_pc = 0;
    m_flags = 3'b000;
  endtask

  task automatic test_alu();
    run({4'h3, 3'd2, 3'd1, 3'd4, 3'd0}, 3'b010, 1'b0);
    tests++;
    if ({o_r, o_s, o_w} !== {3'd1, 3'd4, 3'd2}) begin
      fails++;
      $display("FAIL alu_adr got r%0d s%0d w%0d exp r1 s4 w2",
               o_r, o_s, o_w);
    end
    tests++;
    if ({o_op, o_ssel, o_ds} !== {4'h3, 1'b0, 16'h0}) begin
      fails++;
      $display("FAIL alu_op got op%0h sel%b ds%0h exp 3 0 0",
               o_op, o_ssel, o_ds);
    end
    tests++;
    if ({o_wen_ex, o_wen_wb, o_wen_end} !== 3'b010) begin
      fails++;
      $display("FAIL alu_wen got %b exp 010",
               {o_wen_ex, o_wen_wb, o_wen_end});
    end
    tests++;
    if (o_rdy !== 1'b1 || o_pc !== 8'd1) begin
      fails++;
      $display("FAIL alu_done got rdy%b pc%0h exp rdy1 pc1", o_rdy, o_pc);
    end
    m_pc = wrap(m_pc + 1);
    m_flags = 3'b010;
    tests++;
    if (o_flags !== m_flags) begin
      fails++;
      $display("FAIL alu_flags got %b exp %b", o_flags, m_flags);
    end
  endtask

  task automatic test_ldi();
    run({4'hE, 3'd5, 9'h1FF}, 3'b100, 1'b0);
    tests++;
    if ({o_ds, o_ssel, o_op, o_w} !== {16'hFFFF, 1'b1, 4'hF, 3'd5}) begin
      fails++;
      $display("FAIL ldi_fields got ds%0h sel%b op%0h w%0d exp ffff 1 f 5",
               o_ds, o_ssel, o_op, o_w);
    end
    tests++;
    if ({o_wen_ex, o_wen_wb, o_wen_end} !== 3'b010) begin
      fails++;
      $display("FAIL ldi_wen got %b exp 010",
               {o_wen_ex, o_wen_wb, o_wen_end});
    end
    m_pc = wrap(m_pc + 1);
    m_flags = 3'b100;
    tests++;
    if (o_pc !== PCW'(m_pc) || o_flags !== m_flags) begin
      fails++;
      $display("FAIL ldi_state got pc%0h fl%b exp pc%0h fl%b",
               o_pc, o_flags, m_pc, m_flags);
    end
  endtask

  task automatic test_branch_z();
    goto_pc(0);
    run({4'h1, 3'd1, 3'd2, 3'd3, 3'd0}, 3'b001, 1'b0);
    m_pc = 1;
    m_flags = 3'b001;
    tests++;
    if (o_pc !== 8'd1 || o_flags !== 3'b001) begin
      fails++;
      $display("FAIL bz_setup got pc%0h fl%b exp 1 001", o_pc, o_flags);
    end
    run({4'hF, 2'b01, 10'h3FD}, 3'b000, 1'b0);
    tests++;
    if (o_pc !== 8'hFE || o_wen_ex !== 1'b0) begin
      fails++;
      $display("FAIL bz_taken got pc%0h wen%b exp fe 0", o_pc, o_wen_ex);
    end
    tests++;
    if (o_flags !== 3'b001) begin
      fails++;
      $display("FAIL bz_flags_kept got %b exp 001", o_flags);
    end
    m_pc = 'hFE;
    goto_pc(0);
    run({4'h1, 3'd1, 3'd2, 3'd3, 3'd0}, 3'b110, 1'b0);
    m_pc = 1;
    m_flags = 3'b110;
    run({4'hF, 2'b01, 10'h3FD}, 3'b001, 1'b0);
    tests++;
    if (o_pc !== 8'd2) begin
      fails++;
      $display("FAIL bz_not_taken got pc%0h exp 2", o_pc);
    end
    m_pc = 2;
  endtask

  task automatic test_wrap();
    goto_pc('hFF);
    tests++;
    if (o_pc !== 8'hFF) begin
      fails++;
      $display("FAIL wrap_setup got pc%0h exp ff", o_pc);
    end
    run({4'hF, 2'b00, 10'd2}, 3'b000, 1'b0);
    tests++;
    if (o_pc !== 8'h01) begin
      fails++;
      $display("FAIL wrap_br got pc%0h exp 01", o_pc);
    end
    m_pc = 1;
  endtask

  task automatic test_valid_toggle();
    int w0;
    w0 = wen_cnt;
    for (int i = 0; i < 5; i++) begin
      run({4'(i), 3'(i), 3'd7, 3'd6, 3'd0}, 3'b101, 1'b1);
    end
    m_pc = wrap(m_pc + 5);
    m_flags = 3'b101;
    tests++;
    if (o_pc !== PCW'(m_pc)) begin
      fails++;
      $display("FAIL toggle_pc got pc%0h exp %0h", o_pc, m_pc);
    end
    tests++;
    if (wen_cnt - w0 != 5) begin
      fails++;
      $display("FAIL toggle_writes got %0d exp 5", wen_cnt - w0);
    end
  endtask

  task automatic test_reset_wb();
    bus.instr = {4'h2, 3'd3, 3'd4, 3'd5, 3'd0};
    bus.instr_valid = 1'b1;
    {bus.C, bus.N, bus.Z} = 3'b111;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus.W_En !== 1'b1) begin
      fails++;
      $display("FAIL rwb_in_wb got wen%b exp 1", bus.W_En);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.W_En, bus.instr_ready, bus.busy} !== 3'b000) begin
      fails++;
      $display("FAIL rwb_ctl got %b exp 000",
               {bus.W_En, bus.instr_ready, bus.busy});
    end
    tests++;
    if (bus.pc !== 8'd0 || bus.flags !== 3'b000) begin
      fails++;
      $display("FAIL rwb_abort got pc%0h fl%b exp 0 000",
               bus.pc, bus.flags);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.instr_ready !== 1'b1 || bus.pc !== 8'd0) begin
      fails++;
      $display("FAIL rwb_release got rdy%b pc%0h exp 1 0",
               bus.instr_ready, bus.pc);
    end
    m_pc = 0;
    m_flags = 3'b000;
  endtask

  task automatic test_random();
    logic [15:0] w;
    logic [2:0]  cnz;
    logic [3:0]  op;
    logic [3:0]  e_op;
    logic [15:0] e_ds;
    for (int n = 0; n < 60; n++) begin
      w = 16'($urandom);
      if (n % 4 == 0) w[15:12] = 4'hF;
      if (n % 7 == 0) w[15:12] = 4'hE;
      cnz = 3'($urandom);
      op = w[15:12];
      run(w, cnz, 1'($urandom));
      tests++;
      if (o_to) begin
        fails++;
        $display("FAIL rnd_timeout n%0d got no ready exp ready", n);
        return;
      end
      if (op != 4'hF) begin
        e_op = (op == 4'hE) ? 4'hF : op;
        e_ds = (op == 4'hE) ? 16'(sx(int'(w[8:0]), 9)) : 16'h0;
        tests++;
        if ({o_op, o_ssel, o_ds, o_w} !==
            {e_op, op == 4'hE, e_ds, w[11:9]}) begin
          fails++;
          $display("FAIL rnd_exec n%0d got op%0h sel%b ds%0h w%0d exp %0h %b %0h %0d",
                   n, o_op, o_ssel, o_ds, o_w,
                   e_op, op == 4'hE, e_ds, w[11:9]);
        end
        if (op != 4'hE) begin
          tests++;
          if ({o_r, o_s} !== {w[8:6], w[5:3]}) begin
            fails++;
            $display("FAIL rnd_adr n%0d got r%0d s%0d exp r%0d s%0d",
                     n, o_r, o_s, w[8:6], w[5:3]);
          end
        end
        tests++;
        if ({o_wen_ex, o_rdy_ex, o_busy, o_wen_wb} !== 4'b0011) begin
          fails++;
          $display("FAIL rnd_seq n%0d got %b exp 0011",
                   n, {o_wen_ex, o_rdy_ex, o_busy, o_wen_wb});
        end
        m_pc = wrap(m_pc + 1);
        m_flags = cnz;
      end else begin
        tests++;
        if ({o_wen_ex, o_rdy_ex, o_busy} !== 3'b001) begin
          fails++;
          $display("FAIL rnd_br_seq n%0d got %b exp 001",
                   n, {o_wen_ex, o_rdy_ex, o_busy});
        end
        if (br_taken(w[11:10], m_flags))
          m_pc = wrap(m_pc + sx(int'(w[9:0]), 10));
        else
          m_pc = wrap(m_pc + 1);
      end
      tests++;
      if (o_pc !== PCW'(m_pc) || o_flags !== m_flags) begin
        fails++;
        $display("FAIL rnd_state n%0d w%0h got pc%0h fl%b exp pc%0h fl%b",
                 n, w, o_pc, o_flags, m_pc, m_flags);
      end
      tests++;
      if ({o_rdy, o_wen_end} !== 2'b10) begin
        fails++;
        $display("FAIL rnd_end n%0d got %b exp 10", n, {o_rdy, o_wen_end});
      end
    end
  endtask

  initial begin
    bus.instr = 16'h0;
    bus.instr_valid = 1'b0;
    bus.C = 1'b0;
    bus.N = 1'b0;
    bus.Z = 1'b0;
    test_reset();
    test_alu();
    test_ldi();
    test_branch_z();
    test_wrap();
    test_valid_toggle();
    test_reset_wb();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
